scan_inject_seq: RTL

SCAN_INJECT_SEQ -- requirements
Module: scan_inject_seq

---
 rtl/scan_inject_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/scan_inject_seq.sv
// rtl/scan_inject_seq.sv - LFSR scan-chain fill/check sequencer with optional capture strobe
module scan_inject_seq #(
    parameter int CHAINS    = 2,
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 11
) (
    input  logic              clk,
    input  logic              up_button,
    input  logic              start,
    input  logic              capture_en,
    input  logic [7:0]        seed,
    input  logic [CHAINS-1:0] scan_out,
    output logic              scan_en,
    output logic [CHAINS-1:0] scan_in,
    output logic              capture,
    output logic              busy,
    output logic              done,
    output logic [CHAINS-1:0] fail
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        CHECK = 3'd2,
        CAPT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [7:0]        gen, gen_nxt;
    logic [7:0]        chk, chk_nxt;
    logic              cap_latch, cap_latch_nxt;
    logic              accept;
    logic              shift_nxt;
    logic [7:0]        seed_eff;
    logic [CHAINS-1:0] scan_in_nxt;
    logic [CHAINS-1:0] fail_nxt;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    assign seed_eff = (seed == 8'h00) ? 8'h01 : seed;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cap_latch_nxt = cap_latch;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept        = 1'b1;
                    cap_latch_nxt = capture_en;
                    cnt_nxt       = '0;
                    state_nxt     = FILL;
                end
            end
            FILL: begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            CHECK: begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = cap_latch ? CAPT : DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            CAPT:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // gen holds the word being driven onto the chains in the current cycle.
    always_comb begin
        gen_nxt = gen;
        if (accept) begin
            gen_nxt = seed_eff;
        end else if (state == FILL || state == CHECK) begin
            gen_nxt = lfsr_step(gen);
        end
        shift_nxt = (state_nxt == FILL) || (state_nxt == CHECK);
        scan_in_nxt = '0;
        for (int c = 0; c < CHAINS; c++) begin
            scan_in_nxt[c] = shift_nxt & gen_nxt[c % 8];
        end
    end

    always_comb begin
        chk_nxt  = chk;
        fail_nxt = fail;
        if (accept) begin
            chk_nxt  = seed_eff;
            fail_nxt = '0;
        end else if (state == CHECK) begin
            chk_nxt = lfsr_step(chk);
            for (int c = 0; c < CHAINS; c++) begin
                fail_nxt[c] = fail[c] | (scan_out[c] ^ chk[c % 8]);
            end
        end
    end

    // Outputs are registered from the next-state decode so they align with the state.
    always_ff @(posedge clk) begin
        if (up_button) begin
            state     <= IDLE;
            cnt       <= '0;
            gen       <= 8'h01;
            chk       <= 8'h01;
            cap_latch <= 1'b0;
            scan_en   <= 1'b0;
            scan_in   <= '0;
            capture   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            gen       <= gen_nxt;
            chk       <= chk_nxt;
            cap_latch <= cap_latch_nxt;
            scan_en   <= shift_nxt;
            scan_in   <= scan_in_nxt;
            capture   <= (state_nxt == CAPT);
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            fail      <= fail_nxt;
        end
    end

endmodule
